// File: rtl/avg_pool_unit_pkg.sv
// Shared CNN definitions used by the pool layer and the average unit.
package avg_pool_unit_pkg;

   localparam int unsigned CNN_DATA_W  = 32;
   localparam int unsigned POOL_WINDOW = 4;

   typedef logic signed [CNN_DATA_W-1:0] sample_t;

endpackage

// File: rtl/avg_pool_unit.sv
// Streaming window average: accumulates WINDOW signed samples and registers their
// floor-rounded mean on avg once the last sample of the window arrives.
module avg_pool_unit
   import avg_pool_unit_pkg::*;
#(
   parameter int unsigned DATA_W = CNN_DATA_W,
   parameter int unsigned WINDOW = POOL_WINDOW
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic signed [DATA_W-1:0] layer2,
   output logic signed [DATA_W-1:0] avg
);

   localparam int unsigned SH    = $clog2(WINDOW);
   localparam int unsigned ACC_W = DATA_W + SH;
   localparam logic [SH-1:0] CNT_LAST = SH'(WINDOW - 1);

   if (WINDOW < 2 || (WINDOW & (WINDOW - 1)) != 0) begin : g_window_check
      $error("avg_pool_unit: WINDOW must be a power of two >= 2");
   end

   logic signed [ACC_W-1:0]  r_acc;
   logic        [SH-1:0]     r_cnt;
   logic signed [DATA_W-1:0] r_avg;

   logic signed [ACC_W-1:0]  w_sum;
   logic signed [DATA_W-1:0] w_mean;

   always_comb begin
      w_sum  = r_acc + {{SH{layer2[DATA_W-1]}}, layer2};
      // Taking bits [ACC_W-1:SH] is the arithmetic shift by SH, truncated to DATA_W.
      w_mean = w_sum[ACC_W-1:SH];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_avg <= '0;
      end else if (enable) begin
         if (r_cnt == CNT_LAST) begin
            r_avg <= w_mean;
            r_acc <= '0;
            r_cnt <= '0;
         end else begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + SH'(1);
         end
      end
   end

   assign avg = r_avg;

endmodule

// File: tb/tb_avg_pool_unit.sv
// Directed bench for avg_pool_unit with a reference model and a scoreboard of window results.
module tb_avg_pool_unit;
   import avg_pool_unit_pkg::*;

   logic    clk = 1'b0;
   logic    rst = 1'b0;
   logic    enable = 1'b0;
   sample_t layer2 = '0;
   sample_t avg;

   int total = 0;
   int bad   = 0;

   longint  m_acc  = 0;
   int      m_cnt  = 0;
   sample_t m_last = '0;
   sample_t sb_q[$];

   avg_pool_unit #(
      .DATA_W(CNN_DATA_W),
      .WINDOW(POOL_WINDOW)
   ) u_dut (
      .clk   (clk),
      .rst   (rst),
      .enable(enable),
      .layer2(layer2),
      .avg   (avg)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input sample_t obs, input sample_t exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, obs, obs, exp, exp);
      end
   endtask

   // Drives one enabled sample; enable is left high so consecutive calls are back-to-back.
   task automatic sample(input string tag, input sample_t v);
      bit pushed = 0;
      sample_t e;
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b1;
      layer2 = v;
      m_acc += longint'(v);
      m_cnt++;
      if (m_cnt == POOL_WINDOW) begin
         e = sample_t'(m_acc >>> $clog2(POOL_WINDOW));
         sb_q.push_back(e);
         pushed = 1;
         m_acc  = 0;
         m_cnt  = 0;
      end
      @(posedge clk);
      #1;
      if (pushed) begin
         total++;
         assert (sb_q.size() > 0)
         else begin
            bad++;
            $error("FAIL %s scoreboard_size observed=0 expected>0", tag);
         end
         if (sb_q.size() > 0) begin
            m_last = sb_q.pop_front();
            check(tag, avg, m_last);
         end
      end else begin
         check({tag, "_hold"}, avg, m_last);
      end
   endtask

   // Idle cycles with garbage on layer2; avg must hold.
   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         enable = 1'b0;
         layer2 = sample_t'($urandom);
         @(posedge clk);
         #1;
         check(tag, avg, m_last);
      end
   endtask

   task automatic do_reset(input string tag, input logic en, input sample_t v);
      @(negedge clk);
      rst    = 1'b1;
      enable = en;
      layer2 = v;
      m_acc  = 0;
      m_cnt  = 0;
      m_last = '0;
      @(posedge clk);
      #1;
      check(tag, avg, '0);
      @(negedge clk);
      rst    = 1'b0;
      enable = 1'b0;
   endtask

   initial begin
      do_reset("reset", 1'b0, '0);

      sample("w25_s0", 10);
      sample("w25_s1", 20);
      sample("w25_s2", 30);
      sample("w25_s3", 40);
      idle("hold25", 5);

      sample("neg_s0", -1);
      sample("neg_s1", -2);
      sample("neg_s2", -3);
      sample("neg_s3", -4);
      idle("hold_neg", 1);

      sample("flr_s0", 1);
      sample("flr_s1", 2);
      sample("flr_s2", 1);
      sample("flr_s3", 1);
      idle("hold_flr", 1);

      for (int i = 0; i < 4; i++) sample("maxpos", 32'sh7FFF_FFFF);
      idle("hold_max", 1);
      for (int i = 0; i < 4; i++) sample("maxneg", 32'sh8000_0000);
      idle("hold_min", 1);

      sample("gap_s0", 4);
      sample("gap_s1", 8);
      idle("gap_idle", 3);
      sample("gap_s2", 12);
      sample("gap_s3", 16);
      idle("hold_gap", 1);

      sample("part_s0", 100);
      sample("part_s1", 100);
      do_reset("mid_reset", 1'b1, 100);
      sample("rst_s0", 1);
      sample("rst_s1", 2);
      sample("rst_s2", 3);
      sample("rst_s3", 6);
      idle("hold_rst", 1);

      for (int i = 1; i <= 8; i++) sample($sformatf("cont_s%0d", i), sample_t'(i));
      idle("hold_cont", 2);

      total++;
      assert (sb_q.size() == 0)
      else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
